// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared codes and FSM encoding for the calculator execution stage
package calc_pkg;

  localparam logic [3:0] DT_UNSIGNED = 4'd0;
  localparam logic [3:0] DT_SIGNED   = 4'd1;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd4;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIN
  } calc_state_t;

  function automatic logic cmd_invalid(input logic [3:0] dt, input logic [4:0] op);
    return (dt > DT_SIGNED) || (op < OP_ADD) || (op > OP_DIV);
  endfunction

endpackage

// File: rtl/calc_seq_muldiv.sv
// rtl/calc_seq_muldiv.sv - W-iteration shift-add multiplier / restoring divider on unsigned magnitudes
module calc_seq_muldiv #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] acc_next
);

  localparam int CW = $clog2(W);

  // MUL: acc = {partial product, remaining multiplier}; DIV: acc = {remainder, quotient/dividend}
  logic [2*W-1:0] acc;
  logic [W-1:0]   opb;
  logic           div_mode;
  logic           running;
  logic [CW-1:0]  cnt;
  logic [W:0]     add_sum;
  logic [W:0]     trial;
  logic [W:0]     diff;

  // acc_next is the value after the current step, so the caller can take the final
  // step's result on the same edge that done is seen
  always_comb begin
    add_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
    trial   = acc[2*W-1:W-1];
    diff    = trial - {1'b0, opb};
    if (div_mode) begin
      if (!diff[W]) acc_next = {diff[W-1:0], acc[W-2:0], 1'b1};
      else          acc_next = {trial[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[W-1:1]};
    end
  end

  assign done = running && (cnt == CW'(W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      opb      <= '0;
      div_mode <= 1'b0;
      running  <= 1'b0;
      cnt      <= '0;
    end else if (start) begin
      acc      <= {{W{1'b0}}, a};
      opb      <= b;
      div_mode <= is_div;
      running  <= 1'b1;
      cnt      <= '0;
    end else if (running) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_exec.sv
// rtl/calc_exec.sv - calculator execution stage: single-cycle add/sub, sequential signed/unsigned mul/div
module calc_exec
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           parser_done,
  input  logic [3:0]     dtype,
  input  logic [4:0]     operator,
  input  logic [W-1:0]   src1,
  input  logic [W-1:0]   src2,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   rem,
  output logic           calc_done,
  output logic           calc_err,
  output logic           busy
);

  calc_state_t    state;
  logic           start_ok;
  logic           is_signed;
  logic           is_muldiv;
  logic           bad;
  logic           neg1;
  logic           neg2;
  logic [W-1:0]   mag1;
  logic [W-1:0]   mag2;
  logic [2*W-1:0] ext1;
  logic [2*W-1:0] ext2;
  logic [2*W-1:0] addsub;
  logic           mdu_start;
  logic           mdu_done;
  logic [2*W-1:0] mdu_acc;
  logic           div_r;
  logic           neg_res_r;
  logic           neg_rem_r;
  logic [2*W-1:0] res_mag;
  logic [2*W-1:0] res_final;
  logic [W-1:0]   rem_mag;
  logic [W-1:0]   rem_final;

  always_comb begin
    start_ok  = parser_done && !busy;
    is_signed = (dtype == DT_SIGNED);
    is_muldiv = (operator == OP_MUL) || (operator == OP_DIV);
    bad       = cmd_invalid(dtype, operator) || ((operator == OP_DIV) && (src2 == '0));
    ext1      = is_signed ? {{W{src1[W-1]}}, src1} : {{W{1'b0}}, src1};
    ext2      = is_signed ? {{W{src2[W-1]}}, src2} : {{W{1'b0}}, src2};
    addsub    = (operator == OP_ADD) ? ext1 + ext2 : ext1 - ext2;
    neg1      = is_signed && src1[W-1];
    neg2      = is_signed && src2[W-1];
    // -2^(W-1) maps to magnitude 2^(W-1), which still fits unsigned in W bits
    mag1      = neg1 ? (~src1 + 1'b1) : src1;
    mag2      = neg2 ? (~src2 + 1'b1) : src2;
    mdu_start = start_ok && !bad && is_muldiv;
  end

  calc_seq_muldiv #(.W(W)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (mdu_start),
    .is_div   (operator == OP_DIV),
    .a        (mag1),
    .b        (mag2),
    .done     (mdu_done),
    .acc_next (mdu_acc)
  );

  // quotient is negated at 2W width so that -2^(W-1) / -1 stays positive
  always_comb begin
    rem_mag   = mdu_acc[2*W-1:W];
    res_mag   = div_r ? {{W{1'b0}}, mdu_acc[W-1:0]} : mdu_acc;
    res_final = neg_res_r ? (~res_mag + 1'b1) : res_mag;
    rem_final = div_r ? (neg_rem_r ? (~rem_mag + 1'b1) : rem_mag) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      rem       <= '0;
      calc_done <= 1'b0;
      calc_err  <= 1'b0;
      busy      <= 1'b0;
      div_r     <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      calc_done <= 1'b0;
      case (state)
        ITER: begin
          if (mdu_done) begin
            result    <= res_final;
            rem       <= rem_final;
            calc_err  <= 1'b0;
            calc_done <= 1'b1;
            busy      <= 1'b0;
            state     <= FIN;
          end
        end
        default: begin
          // FIN accepts a new start exactly like IDLE
          state <= IDLE;
          if (start_ok) begin
            if (bad) begin
              result    <= '0;
              rem       <= '0;
              calc_err  <= 1'b1;
              calc_done <= 1'b1;
            end else if (!is_muldiv) begin
              result    <= addsub;
              rem       <= '0;
              calc_err  <= 1'b0;
              calc_done <= 1'b1;
            end else begin
              div_r     <= (operator == OP_DIV);
              neg_res_r <= neg1 ^ neg2;
              neg_rem_r <= neg1;
              busy      <= 1'b1;
              state     <= ITER;
            end
          end
        end
      endcase
    end
  end

endmodule
